// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_pkg
// Description : Shared constants and decoder state type for the 8-bit FP
//               sample format (S / 3-bit E / 4-bit F).
// Revision    : 1.0 - initial release
// ============================================================================
package fp_pkg;

    localparam int FP_D_W = 12;
    localparam int FP_E_W = 3;
    localparam int FP_F_W = 4;

    // Largest decodable magnitude: 15 * 2^7
    localparam logic [FP_D_W-1:0] FP_MAX_MAG = 12'h780;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        SIGN  = 2'd2,
        OUT   = 2'd3
    } fp_dec_state_t;

endpackage
`default_nettype wire

// File: rtl/fp_mag_shifter.sv
`default_nettype none
// ============================================================================
// Module      : fp_mag_shifter
// Description : Iterative magnitude builder; shifts the significand left one
//               place per step until the exponent count is exhausted.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mag_shifter
    import fp_pkg::*;
#(
    parameter int D_W = FP_D_W,
    parameter int E_W = FP_E_W,
    parameter int F_W = FP_F_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load,
    input  logic           step,
    input  logic [E_W-1:0] e_in,
    input  logic [F_W-1:0] f_in,
    output logic [D_W-1:0] acc,
    output logic           done
);

    logic [D_W-1:0] r_acc;
    logic [E_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
        end else if (load) begin
            r_acc <= {{(D_W-F_W){1'b0}}, f_in};
            r_cnt <= e_in;
        end else if (step) begin
            r_acc <= r_acc << 1;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Final shift happens on the step taken while the count reads one
    assign done = (r_cnt == E_W'(1));
    assign acc  = r_acc;

endmodule
`default_nettype wire

// File: rtl/fp_to_twos.sv
`default_nettype none
// ============================================================================
// Module      : fp_to_twos
// Description : Sequential FP(S,E,F) to two's-complement integer decoder with
//               valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_to_twos
    import fp_pkg::*;
#(
    parameter int D_W = FP_D_W,
    parameter int E_W = FP_E_W,
    parameter int F_W = FP_F_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           S,
    input  logic [E_W-1:0] E,
    input  logic [F_W-1:0] F,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [D_W-1:0] D,
    output logic           busy
);

    fp_dec_state_t  r_state;
    fp_dec_state_t  w_state_next;
    logic           r_s;
    logic [D_W-1:0] r_d;
    logic [D_W-1:0] w_acc;
    logic           w_done;
    logic           w_load;
    logic           w_step;

    fp_mag_shifter #(
        .D_W (D_W),
        .E_W (E_W),
        .F_W (F_W)
    ) u_shifter (
        .clk  (clk),
        .rst  (rst),
        .load (w_load),
        .step (w_step),
        .e_in (E),
        .f_in (F),
        .acc  (w_acc),
        .done (w_done)
    );

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_load       = 1'b1;
                    w_state_next = (E != '0) ? SHIFT : SIGN;
                end
            end
            SHIFT: begin
                w_step = 1'b1;
                if (w_done) begin
                    w_state_next = SIGN;
                end
            end
            SIGN: begin
                w_state_next = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_s     <= 1'b0;
            r_d     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load) begin
                r_s <= S;
            end
            // Modulo negation; a negative zero naturally wraps back to zero
            if (r_state == SIGN) begin
                r_d <= r_s ? (~w_acc + 1'b1) : w_acc;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == OUT);
    assign busy      = (r_state != IDLE);
    assign D         = r_d;

endmodule
`default_nettype wire

// File: tb/tb_fp_to_twos.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_to_twos
// Description : Self-checking bench: vector table plus scoreboard queue fed at
//               stimulus time and drained by an output-handshake monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_to_twos;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        S = 1'b0;
    logic [2:0]  E = '0;
    logic [3:0]  F = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] D;
    logic        busy;

    int total = 0;
    int bad   = 0;
    logic [11:0] sb[$];

    typedef struct {
        logic        s;
        logic [2:0]  e;
        logic [3:0]  f;
        logic [11:0] exp_d;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    fp_to_twos dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
        .busy      (busy)
    );

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] model(input logic s, input logic [2:0] e, input logic [3:0] f);
        int mag = int'(f) << e;
        int d   = s ? -mag : mag;
        return d[11:0];
    endfunction

    // Output handshake monitor: each completed transfer must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                check("D_result", int'(D), int'(sb.pop_front()));
            end
        end
    end

    task automatic send(input logic s, input logic [2:0] e, input logic [3:0] f,
                        input logic [11:0] exp_d);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_before_send", int'(in_ready), 1);
        S = s; E = e; F = f; in_valid = 1'b1;
        sb.push_back(exp_d);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Called just after the accepting edge; latency counts the accept cycle as cycle 0
    task automatic wait_out(input int e);
        int   n = 0;
        logic busy_ok = 1'b1;
        while (!out_valid && n < 40) begin
            busy_ok &= busy;
            @(posedge clk); #1; n++;
        end
        check("busy_during_conversion", int'(busy_ok), 1);
        check("latency", n + 1, e + 2);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 3'd0, 4'd5,  12'h005};
        vecs[1] = '{1'b0, 3'd7, 4'd15, 12'h780};
        vecs[2] = '{1'b1, 3'd3, 4'd9,  12'hFB8};
        vecs[3] = '{1'b1, 3'd7, 4'd15, 12'h880};
        vecs[4] = '{1'b1, 3'd5, 4'd0,  12'h000};
        vecs[5] = '{1'b0, 3'd4, 4'd1,  12'h010};
        vecs[6] = '{1'b1, 3'd0, 4'd1,  12'hFFF};
        vecs[7] = '{1'b0, 3'd3, 4'd10, 12'h050};
        vecs[8] = '{1'b1, 3'd2, 4'd6,  12'hFE8};

        // Reset state
        #12;
        check("reset_D", int'(D), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Table-driven conversions with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(vecs[i].s, vecs[i].e, vecs[i].f, vecs[i].exp_d);
            wait_out(int'(vecs[i].e));
            @(posedge clk); #1;
            check("out_valid_one_cycle", int'(out_valid), 0);
            check("idle_after_output", int'(in_ready), 1);
        end

        // A few more against the arithmetic model
        for (int i = 0; i < 6; i++) begin
            logic       rs;
            logic [2:0] re;
            logic [3:0] rf;
            rs = 1'($urandom_range(0, 1));
            re = 3'($urandom_range(0, 7));
            rf = 4'($urandom_range(0, 15));
            send(rs, re, rf, model(rs, re, rf));
            wait_out(int'(re));
            @(posedge clk); #1;
        end

        // Backpressure in OUT with new data offered throughout
        out_ready = 1'b0;
        send(1'b0, 3'd2, 4'd3, 12'h00C);
        wait_out(2);
        S = 1'b1; E = 3'd4; F = 4'd7; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_D_stable", int'(D), 'h00C);
            check("bp_out_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        sb.push_back(12'hF90);
        @(posedge clk); #1;
        check("no_accept_in_out", int'(in_ready), 1);
        check("out_valid_dropped", int'(out_valid), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("accepted_after_out", int'(in_ready), 0);
        wait_out(4);
        @(posedge clk); #1;

        // Reset in the middle of a SHIFT phase; the conversion must vanish
        S = 1'b0; E = 3'd6; F = 4'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("busy_before_reset", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("rst_D", int'(D), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_busy", int'(busy), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 15; i++) begin
                @(posedge clk); #1;
                if (out_valid) seen++;
            end
            check("no_result_after_reset", seen, 0);
        end
        send(1'b0, 3'd1, 4'd1, 12'h002);
        wait_out(1);
        @(posedge clk); #1;
        @(posedge clk); #1;

        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
